// File: rtl/bus_wait_ctrl.sv
// CPU-side wait-state controller: posts writes into a small FIFO and stalls
// reads until the data is forwarded from the FIFO, the read buffer or memory.
module bus_wait_ctrl #(
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_data_o,
  output logic [7:0]  cpu_data_i,
  output logic        cpu_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        wbuf_overflow
);

  localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t        state_q, state_d;
  logic          memReq_q, memReq_d;
  logic          memWe_q, memWe_d;
  logic [15:0]   memAddr_q, memAddr_d;
  logic [7:0]    memWdata_q, memWdata_d;

  logic          rdValid_q, rdValid_d;
  logic [15:0]   rdAddr_q, rdAddr_d;
  logic [7:0]    rdData_q, rdData_d;
  logic          overflow_q, overflow_d;

  logic [15:0]   fifoAddr_q [WBUF_DEPTH];
  logic [7:0]    fifoData_q [WBUF_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          fifoFull;
  logic          fifoHit;
  logic [7:0]    fifoHitData;
  logic [PW-1:0] idx;
  logic          rdHit;
  logic          readMiss;
  logic          pop;
  logic          pushOk;

  assign fifoFull = (count_q == CW'(WBUF_DEPTH));
  assign pop      = (state_q == WR) && mem_ack;
  assign pushOk   = cpu_write && (!fifoFull || pop);

  // Walk the live entries oldest-first so the youngest match wins.
  always_comb begin
    fifoHit     = 1'b0;
    fifoHitData = 8'h00;
    idx         = rptr_q;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      idx = rptr_q + PW'(k);
      if ((CW'(k) < count_q) && (fifoAddr_q[idx] == cpu_address)) begin
        fifoHit     = 1'b1;
        fifoHitData = fifoData_q[idx];
      end
    end
  end

  assign rdHit    = rdValid_q && (rdAddr_q == cpu_address);
  assign readMiss = !cpu_write && !fifoHit && !rdHit;

  always_comb begin
    cpu_ready  = 1'b0;
    cpu_data_i = 8'h00;
    if (reset) begin
      if (cpu_write) begin
        cpu_ready = 1'b1;
      end else if (fifoHit) begin
        cpu_ready  = 1'b1;
        cpu_data_i = fifoHitData;
      end else if (rdHit) begin
        cpu_ready  = 1'b1;
        cpu_data_i = rdData_q;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    case (state_q)
      IDLE: begin
        if (readMiss) begin
          state_d    = RD;
          memReq_d   = 1'b1;
          memWe_d    = 1'b0;
          memAddr_d  = cpu_address;
          memWdata_d = 8'h00;
        end else if (count_q != '0) begin
          state_d    = WR;
          memReq_d   = 1'b1;
          memWe_d    = 1'b1;
          memAddr_d  = fifoAddr_q[rptr_q];
          memWdata_d = fifoData_q[rptr_q];
        end
      end
      RD, WR: begin
        if (mem_ack) begin
          state_d  = IDLE;
          memReq_d = 1'b0;
          memWe_d  = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        memReq_d = 1'b0;
        memWe_d  = 1'b0;
      end
    endcase
  end

  // Read buffer: a fresh capture wins unless the same address is written at that edge.
  always_comb begin
    rdValid_d = rdValid_q;
    rdAddr_d  = rdAddr_q;
    rdData_d  = rdData_q;
    if (!cpu_write && !fifoHit && rdHit) begin
      rdValid_d = 1'b0;
    end
    if (cpu_write && (cpu_address == rdAddr_q)) begin
      rdValid_d = 1'b0;
    end
    if ((state_q == RD) && mem_ack) begin
      rdData_d  = mem_rdata;
      rdAddr_d  = memAddr_q;
      rdValid_d = !(cpu_write && (cpu_address == memAddr_q));
    end
  end

  always_comb begin
    wptr_d     = pushOk ? wptr_q + PW'(1) : wptr_q;
    rptr_d     = pop ? rptr_q + PW'(1) : rptr_q;
    count_d    = count_q + CW'(pushOk) - CW'(pop);
    overflow_d = overflow_q || (cpu_write && fifoFull && !pop);
  end

  always_ff @(posedge clk) begin
    if (pushOk) begin
      fifoAddr_q[wptr_q] <= cpu_address;
      fifoData_q[wptr_q] <= cpu_data_o;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= 16'h0000;
      memWdata_q <= 8'h00;
      rdValid_q  <= 1'b0;
      rdAddr_q   <= 16'h0000;
      rdData_q   <= 8'h00;
      overflow_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      rdValid_q  <= rdValid_d;
      rdAddr_q   <= rdAddr_d;
      rdData_q   <= rdData_d;
      overflow_q <= overflow_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
    end
  end

  assign mem_req       = memReq_q;
  assign mem_we        = memWe_q;
  assign mem_addr      = memAddr_q;
  assign mem_wdata     = memWdata_q;
  assign wbuf_overflow = overflow_q;

endmodule

// File: doc/bus_wait_ctrl.md
BUS_WAIT_CTRL -- requirements
Module: bus_wait_ctrl

Interface
REQ-001 SHALL have parameter: WBUF_DEPTH, 4, posted-write buffer entries; power of two, 2..8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: cpu_address  input  16  CPU bus address, valid every cycle.
REQ-005 SHALL have port: cpu_write  input  1  1 = current CPU cycle is a write.
REQ-006 SHALL have port: cpu_data_o  input  8  CPU write data.
REQ-007 SHALL have port: cpu_data_i  output  8  read data to CPU.
REQ-008 SHALL have port: cpu_ready  output  1  ready to CPU; low stalls a CPU read cycle.
REQ-009 SHALL have port: mem_req  output  1  memory request.
REQ-010 SHALL have port: mem_we  output  1  request is a write.
REQ-011 SHALL have port: mem_addr  output  16  request address.
REQ-012 SHALL have port: mem_wdata  output  8  request write data.
REQ-013 SHALL have port: mem_ack  input  1  one-cycle completion strobe.
REQ-014 SHALL have port: mem_rdata  input  8  read data, valid with mem_ack.
REQ-015 SHALL have port: wbuf_overflow  output  1  sticky error; a write was dropped.

Function
REQ-016 SHALL treat every cycle as a CPU bus cycle; the CPU ignores ready on write cycles, so writes SHALL never stall and are posted into a FIFO of WBUF_DEPTH {addr,data} entries.
REQ-017 SHALL drive cpu_ready=1 in every cycle with cpu_write=1.
REQ-018 SHALL issue at most one memory transaction at a time; mem_req, mem_we, mem_addr and mem_wdata SHALL be registered and held stable from assertion until the edge at which mem_ack=1 is sampled.
REQ-019 SHALL deassert mem_req in the cycle after ack; the next request SHALL be assertable no earlier than that same cycle.
REQ-020 SHALL implement FSM IDLE, RD, WR: IDLE->RD when a read miss is pending (REQ-022); IDLE->WR when FIFO non-empty and no read miss; RD/WR->IDLE on mem_ack.
REQ-021 On a read cycle (cpu_write=0), cpu_ready and cpu_data_i SHALL follow priority: (a) address matches a FIFO entry -> forward youngest matching data, cpu_ready=1 same cycle; (b) rd_valid=1 and rd_addr==cpu_address -> drive rd_data, cpu_ready=1; (c) else cpu_ready=0.
REQ-022 Case (c) is a read miss; the read SHALL take priority over FIFO drain in IDLE.
REQ-023 On read ack: rd_data<=mem_rdata, rd_addr<=mem_addr, rd_valid<=1; miss-to-ready latency SHALL be ack cycle +1.
REQ-024 If cpu_address differs from mem_addr at ack, the data SHALL still be captured, cpu_ready stays 0, and a new miss is issued from IDLE.
REQ-025 rd_valid SHALL clear on the edge where the CPU consumes it (read cycle, cpu_ready=1 via case b) and on any posted write whose address equals rd_addr.
REQ-026 FIFO push SHALL occur on every write-cycle edge; pop on a WR-state ack; simultaneous push and pop on a full FIFO SHALL succeed.
REQ-027 Push into a full FIFO without simultaneous pop SHALL drop the write and set wbuf_overflow until reset.
REQ-028 FIFO pointers SHALL wrap modulo WBUF_DEPTH with a separate count for full/empty.
REQ-029 cpu_data_i SHALL be 8'h00 when cpu_ready=0.

Reset
REQ-030 While reset=0: FSM=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, FIFO empty, rd_valid=0, wbuf_overflow=0, cpu_ready=0, cpu_data_i=0.
REQ-031 Reset asserted mid-transaction SHALL abort it; a late mem_ack after release SHALL be ignored while in IDLE.

Verification
REQ-032 Read 0x1234, memory acks after 3 cycles with 0x5A -> cpu_ready low 3 cycles, high on the next with cpu_data_i=0x5A; exactly one mem_req.
REQ-033 Writes 0x01FF<=0x11, 0x01FE<=0x22, 0x01FD<=0x33 back-to-back, memory acks after 2 cycles -> cpu_ready=1 throughout; memory sees three writes in order; no overflow.
REQ-034 Write 0x0200<=0xAA, then read 0x0200 before drain -> cpu_ready=1 same cycle, cpu_data_i=0xAA, no read request issued.
REQ-035 WBUF_DEPTH=4, mem_ack tied 0, 5 consecutive writes -> fifth dropped, wbuf_overflow=1 and stays 1 after FIFO drains.
REQ-036 Read miss outstanding, reset pulsed low for 1 cycle, then mem_ack -> mem_req=0, cpu_ready=0, rd_valid=0, ack ignored.
